// File: rtl/arb_muxn_pkg.sv
// Shared NoC definitions for the flit arbiters: lock-state encoding,
// channel-count limits and the source-index width helper.
package arb_muxn_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    localparam int unsigned N_IN_MAX      = 16;
    localparam int unsigned FLIT_WIDTH_DEF = 32;

    // Width of a channel index; never narrower than one bit so N_IN=1 still
    // yields a legal port.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_muxn_rr_arbiter.sv
// Round-robin priority search starting at ptr, with an optional lock that
// restricts eligibility to a single source.
module rr_arbiter
    import arb_muxn_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SRC_W = src_w(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    input  logic             lock_en,
    input  logic [SRC_W-1:0] lock_src,
    output logic [SRC_W-1:0] grant,
    output logic             grant_vld
);

    // First requester at or after ptr (wrapping), or only lock_src when locked
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (lock_en) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (lock_src == SRC_W'(i) && req[i]) begin
                    grant     = SRC_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                // ptr < N_IN, so a single conditional subtract wraps the offset
                idx = 32'(ptr) + k;
                if (idx >= N_IN) idx = idx - N_IN;
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (!grant_vld && idx == i && req[i]) begin
                        grant     = SRC_W'(i);
                        grant_vld = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/arb_muxn.sv
// N-input flit arbiter/mux with round-robin fairness, optional packet lock
// and a single registered output stage with full-throughput backpressure.
module arb_muxn
    import arb_muxn_pkg::*;
#(
    parameter  int unsigned N_IN     = 4,
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned PKT_LOCK = 1,
    localparam int unsigned SRC_W    = src_w(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready
);

    lock_state_e      state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [SRC_W-1:0] lock_src_q, lock_src_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [SRC_W-1:0] out_src_q;

    logic             load_en;
    logic             lock_en;
    logic [SRC_W-1:0] grant;
    logic             grant_vld;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    assign load_en = !out_valid_q || out_ready;
    assign lock_en = (PKT_LOCK != 0) && (state_q == ST_LOCKED);
    assign xfer    = !rst && load_en && grant_vld;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SRC_W (SRC_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .lock_en   (lock_en),
        .lock_src  (lock_src_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // N-way select of the granted channel's payload/last and its ready strobe
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_last    = in_last[i];
                in_ready[i] = xfer;
            end
        end
    end

    // Next round-robin pointer and packet-lock state
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            if (PKT_LOCK == 0 || sel_last)
                ptr_d = (grant == SRC_W'(N_IN - 1)) ? '0 : grant + 1'b1;
            if (PKT_LOCK != 0) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!sel_last) begin
                            state_d    = ST_LOCKED;
                            lock_src_d = grant;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_last) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_src_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            ptr_q      <= ptr_d;
        end
    end

    // Output stage: load on a granted transfer, empty when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= sel_last;
                out_src_q   <= grant;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_muxn.sv
// Directed bench for arb_muxn: locked 4-channel, unlocked 4-channel and
// single-channel instances driven in sequence from one initial block.
module tb_arb_muxn;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: N_IN=4, WIDTH=32, PKT_LOCK=1
    logic [3:0]   a_valid, a_last, a_ready;
    logic [127:0] a_data;
    logic         a_ovalid, a_olast, a_oready;
    logic [31:0]  a_odata;
    logic [1:0]   a_osrc;

    // Instance B: N_IN=4, WIDTH=32, PKT_LOCK=0
    logic [3:0]   b_valid, b_last, b_ready;
    logic [127:0] b_data;
    logic         b_ovalid, b_olast, b_oready;
    logic [31:0]  b_odata;
    logic [1:0]   b_osrc;

    // Instance C: N_IN=1, WIDTH=8
    logic [0:0]   c_valid, c_last, c_ready;
    logic [7:0]   c_data;
    logic         c_ovalid, c_olast, c_oready;
    logic [7:0]   c_odata;
    logic [0:0]   c_osrc;

    arb_muxn #(.N_IN(4), .WIDTH(32), .PKT_LOCK(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
        .in_last(a_last), .in_ready(a_ready), .out_valid(a_ovalid),
        .out_data(a_odata), .out_last(a_olast), .out_src(a_osrc),
        .out_ready(a_oready));

    arb_muxn #(.N_IN(4), .WIDTH(32), .PKT_LOCK(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data),
        .in_last(b_last), .in_ready(b_ready), .out_valid(b_ovalid),
        .out_data(b_odata), .out_last(b_olast), .out_src(b_osrc),
        .out_ready(b_oready));

    arb_muxn #(.N_IN(1), .WIDTH(8), .PKT_LOCK(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data),
        .in_last(c_last), .in_ready(c_ready), .out_valid(c_ovalid),
        .out_data(c_odata), .out_last(c_olast), .out_src(c_osrc),
        .out_ready(c_oready));

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] src, input logic [31:0] data,
                         input logic last);
        chk({tag, "_valid"}, 32'(a_ovalid), 32'd1);
        chk({tag, "_src"},   32'(a_osrc),   32'(src));
        chk({tag, "_data"},  a_odata,       data);
        chk({tag, "_last"},  32'(a_olast),  32'(last));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] src, input logic [31:0] data,
                         input logic last);
        chk({tag, "_valid"}, 32'(b_ovalid), 32'd1);
        chk({tag, "_src"},   32'(b_osrc),   32'(src));
        chk({tag, "_data"},  b_odata,       data);
        chk({tag, "_last"},  32'(b_olast),  32'(last));
    endtask

    logic [7:0]  sb_q[$];
    logic [7:0]  next_byte;
    logic [7:0]  obs_byte;
    logic [7:0]  exp_byte;
    logic        fin, fout;
    int unsigned n_in, n_out;

    initial begin
        rst      = 1'b1;
        a_valid  = 4'b1111;
        a_last   = 4'b1111;
        a_oready = 1'b1;
        for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'h100 + 32'(i);
        b_valid  = '0; b_last = '0; b_data = '0; b_oready = 1'b1;
        c_valid  = '0; c_last = '0; c_data = '0; c_oready = 1'b1;

        // Reset behaviour
        #1;
        chk("rst_ready_a", 32'(a_ready), 32'h0);
        tick();
        tick();
        chk("rst_ready_a2", 32'(a_ready), 32'h0);
        chk("rst_ovalid_a", 32'(a_ovalid), 32'h0);
        chk("rst_odata_a",  a_odata,       32'h0);
        chk("rst_olast_a",  32'(a_olast),  32'h0);
        chk("rst_osrc_a",   32'(a_osrc),   32'h0);
        chk("rst_ovalid_b", 32'(b_ovalid), 32'h0);
        chk("rst_ovalid_c", 32'(c_ovalid), 32'h0);
        chk("rst_osrc_c",   32'(c_osrc),   32'h0);

        // Round robin over four single-flit streams
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_ready", 32'(a_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk_a("rr", 2'(i % 4), 32'h100 + 32'(i % 4), 1'b1);
        end
        a_valid = '0;
        #1;
        chk("idle_ready", 32'(a_ready), 32'h0);
        tick();
        chk("idle_ovalid", 32'(a_ovalid), 32'h0);

        // Packet lock: ch1 3-flit packet, ch2 waiting, with a bubble inside
        a_data[1*32 +: 32] = 32'hA1; a_last[1] = 1'b0;
        a_data[2*32 +: 32] = 32'hC2; a_last[2] = 1'b1;
        a_valid = 4'b0110;
        #1;
        chk("lk1_ready", 32'(a_ready), 32'b0010);
        tick();
        chk_a("lk1", 2'd1, 32'hA1, 1'b0);
        a_data[1*32 +: 32] = 32'hA2;
        #1;
        chk("lk2_ready", 32'(a_ready), 32'b0010);
        tick();
        chk_a("lk2", 2'd1, 32'hA2, 1'b0);
        a_valid = 4'b0100;
        #1;
        chk("bubble_ready", 32'(a_ready), 32'h0);
        tick();
        chk("bubble_ovalid", 32'(a_ovalid), 32'h0);
        a_valid = 4'b0110;
        a_data[1*32 +: 32] = 32'hA3; a_last[1] = 1'b1;
        #1;
        chk("lk3_ready", 32'(a_ready), 32'b0010);
        tick();
        chk_a("lk3", 2'd1, 32'hA3, 1'b1);
        a_valid = 4'b0100;
        #1;
        chk("lk4_ready", 32'(a_ready), 32'b0100);
        tick();
        chk_a("lk4", 2'd2, 32'hC2, 1'b1);

        // Backpressure hold on ch3, then back-to-back release
        a_valid = 4'b1000;
        a_data[3*32 +: 32] = 32'hDEADBEEF; a_last[3] = 1'b1;
        #1;
        chk("bp0_ready", 32'(a_ready), 32'b1000);
        tick();
        chk_a("bp0", 2'd3, 32'hDEADBEEF, 1'b1);
        a_oready = 1'b0;
        a_data[3*32 +: 32] = 32'h0BADF00D;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ready", 32'(a_ready), 32'h0);
            tick();
            chk_a("bp_hold", 2'd3, 32'hDEADBEEF, 1'b1);
        end
        a_oready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(a_ready), 32'b1000);
        tick();
        chk_a("bp_rel", 2'd3, 32'h0BADF00D, 1'b1);
        a_valid = '0;
        tick();
        chk("bp_idle", 32'(a_ovalid), 32'h0);

        // Reset mid-packet drops the lock and the held flit
        a_valid = 4'b0001;
        a_data[0*32 +: 32] = 32'hD0; a_last[0] = 1'b0;
        #1;
        chk("mp0_ready", 32'(a_ready), 32'b0001);
        tick();
        chk_a("mp0", 2'd0, 32'hD0, 1'b0);
        a_data[0*32 +: 32] = 32'hD1;
        tick();
        chk_a("mp1", 2'd0, 32'hD1, 1'b0);
        a_valid = 4'b0101;
        a_data[2*32 +: 32] = 32'hE2; a_last[2] = 1'b1;
        #1;
        chk("mp_locked_ready", 32'(a_ready), 32'b0001);
        rst = 1'b1;
        #1;
        chk("mp_rst_ready", 32'(a_ready), 32'h0);
        tick();
        chk("mp_rst_ovalid", 32'(a_ovalid), 32'h0);
        chk("mp_rst_odata",  a_odata,       32'h0);
        chk("mp_rst_osrc",   32'(a_osrc),   32'h0);
        rst = 1'b0;
        a_valid = 4'b0100;
        #1;
        chk("mp_ch2_ready", 32'(a_ready), 32'b0100);
        tick();
        chk_a("mp_ch2", 2'd2, 32'hE2, 1'b1);
        a_valid = 4'b1111; a_last = 4'b1111;
        #1;
        chk("ptr3_ready", 32'(a_ready), 32'b1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ptr_rst_ready", 32'(a_ready), 32'b0001);
        a_valid = '0;
        tick();

        // Unlocked interleave of two multi-flit streams
        b_valid = 4'b0011;
        b_data[0*32 +: 32] = 32'hA0; b_last[0] = 1'b0;
        b_data[1*32 +: 32] = 32'hB0; b_last[1] = 1'b0;
        #1;
        chk("il0_ready", 32'(b_ready), 32'b0001);
        tick();
        chk_b("il0", 2'd0, 32'hA0, 1'b0);
        b_data[0*32 +: 32] = 32'hA1; b_last[0] = 1'b1;
        #1;
        chk("il1_ready", 32'(b_ready), 32'b0010);
        tick();
        chk_b("il1", 2'd1, 32'hB0, 1'b0);
        b_data[1*32 +: 32] = 32'hB1; b_last[1] = 1'b1;
        #1;
        chk("il2_ready", 32'(b_ready), 32'b0001);
        tick();
        chk_b("il2", 2'd0, 32'hA1, 1'b1);
        #1;
        chk("il3_ready", 32'(b_ready), 32'b0010);
        tick();
        chk_b("il3", 2'd1, 32'hB1, 1'b1);
        b_valid = '0;
        tick();
        chk("il_idle", 32'(b_ovalid), 32'h0);

        // Single-channel random valid/ready stress against an in-order queue
        next_byte = 8'd1;
        n_in = 0;
        n_out = 0;
        c_last = 1'b1;
        for (int cyc = 0; cyc < 220; cyc++) begin
            if (cyc < 200) begin
                c_valid  = 1'($urandom_range(0, 1));
                c_oready = 1'($urandom_range(0, 1));
            end else begin
                c_valid  = 1'b0;
                c_oready = 1'b1;
            end
            c_data = next_byte;
            #1;
            fin      = c_valid[0] && c_ready[0];
            fout     = c_ovalid && c_oready;
            obs_byte = c_odata;
            tick();
            if (fout) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("c_spurious", 32'(obs_byte), 32'hFFFF_FFFF);
                end else begin
                    exp_byte = sb_q.pop_front();
                    chk("c_order", 32'(obs_byte), 32'(exp_byte));
                end
            end
            if (fin) begin
                sb_q.push_back(next_byte);
                next_byte = next_byte + 8'd1;
                n_in++;
            end
        end
        chk("c_drained", 32'(sb_q.size()), 32'h0);
        chk("c_count",   n_out, n_in);
        chk("c_osrc",    32'(c_osrc), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
